// File: rtl/vive_pkg.sv
// Shared widths, entry layout and pack/unpack helpers for the decoded frame buffer.
// An entry is {ch_id, data, ts}, with ch_id in the top bits.
package vive_pkg;
   localparam int DATA_W   = 17;
   localparam int TS_W     = 24;
   localparam int CH_W     = 3;
   localparam int ENTRY_W  = CH_W + DATA_W + TS_W;
   localparam int CH_LSB   = DATA_W + TS_W;
   localparam int DATA_LSB = TS_W;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_FILL  = 2'd1,
      WR_CLOSE = 2'd2
   } wr_state_t;

   function automatic logic [ENTRY_W-1:0] pack_entry(input logic [CH_W-1:0] ch,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [TS_W-1:0] ts);
      return {ch, data, ts};
   endfunction

   function automatic logic [CH_W-1:0] entry_ch(input logic [ENTRY_W-1:0] e);
      return e[CH_LSB +: CH_W];
   endfunction

   function automatic logic [DATA_W-1:0] entry_data(input logic [ENTRY_W-1:0] e);
      return e[DATA_LSB +: DATA_W];
   endfunction

   function automatic logic [TS_W-1:0] entry_ts(input logic [ENTRY_W-1:0] e);
      return e[TS_W-1:0];
   endfunction
endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM holding both frame banks, addressed by {bank_sel, idx}.
// Registered read port and no reset, so it maps onto block RAM.
module frame_bank_ram #(
   parameter int AW = 9,
   parameter int DW = 44
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [0:(2**AW)-1];

   // Write port and registered read port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end
endmodule

// File: rtl/decoded_frame_buffer.sv
// Multi-channel capture of BMC-decoded words into ping-pong frame banks,
// with round-robin arbitration, idle-gap frame close and an indexed read port.
module decoded_frame_buffer
   import vive_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DEPTH      = 196,
   parameter int IDLE_TICKS = 96000
) (
   input  logic                     clk_96MHz,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] decoded_data,
   input  logic [NUM_CH*TS_W-1:0]   ts_decoded_data,
   input  logic [NUM_CH-1:0]        decoded_data_avl,
   output logic [NUM_CH-1:0]        reset_bmc_decoder,
   output logic                     frame_ready,
   output logic [7:0]               frame_len,
   output logic                     frame_ovf,
   output logic [7:0]               drop_cnt,
   input  logic                     rd_en,
   input  logic [7:0]               rd_idx,
   output logic [ENTRY_W-1:0]       rd_data,
   output logic                     rd_valid,
   output logic                     rd_err,
   input  logic                     frame_release
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(IDLE_TICKS + 1);

   wr_state_t           state_r;
   logic [NUM_CH-1:0]   mask1_r, mask2_r, ack_r, grant_s;
   logic [7:0]          elig8_s;
   logic [CH_W-1:0]     ptr_r, gnt_ch_s, ptr_next_s;
   logic                gnt_any_s, hit_s, release_s, rd_bad_s;
   int                  cand_s;
   logic [DATA_W-1:0]   sel_data_s;
   logic [TS_W-1:0]     sel_ts_s;
   logic [CNT_W-1:0]    idle_r;
   logic [7:0]          wr_len_r;
   logic                wr_ovf_r, wr_bank_r;
   logic                we_r;
   logic [IDX_W:0]      waddr_r;
   logic [ENTRY_W-1:0]  wdata_r, ram_q_s;
   logic                frame_ready_r, frame_ovf_r, rd_valid_r, rd_err_r;
   logic [7:0]          frame_len_r, drop_cnt_r;

   // Round-robin pick starting at ptr_r; grants are held off during CLOSE.
   always_comb begin
      elig8_s   = 8'(decoded_data_avl & ~(mask1_r | mask2_r));
      gnt_any_s = 1'b0;
      gnt_ch_s  = {CH_W{1'b0}};
      cand_s    = 0;
      hit_s     = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand_s    = (int'(ptr_r) + i >= NUM_CH) ? int'(ptr_r) + i - NUM_CH : int'(ptr_r) + i;
         hit_s     = !gnt_any_s && (state_r != WR_CLOSE) && elig8_s[CH_W'(cand_s)];
         gnt_ch_s  = hit_s ? CH_W'(cand_s) : gnt_ch_s;
         gnt_any_s = gnt_any_s | hit_s;
      end
      ptr_next_s = (int'(gnt_ch_s) + 1 >= NUM_CH) ? {CH_W{1'b0}} : gnt_ch_s + 3'd1;
   end

   // One-hot grant and the granted channel's word/timestamp.
   always_comb begin
      grant_s    = {NUM_CH{1'b0}};
      sel_data_s = {DATA_W{1'b0}};
      sel_ts_s   = {TS_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         grant_s[i] = gnt_any_s && (gnt_ch_s == CH_W'(i));
         sel_data_s = grant_s[i] ? decoded_data[i*DATA_W +: DATA_W] : sel_data_s;
         sel_ts_s   = grant_s[i] ? ts_decoded_data[i*TS_W +: TS_W] : sel_ts_s;
      end
   end

   assign release_s = frame_release && frame_ready_r;
   assign rd_bad_s  = !frame_ready_r || (rd_idx >= frame_len_r);

   // Arbiter state, write FSM, bank swap and read-side flags.
   always_ff @(posedge clk_96MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= WR_IDLE;
         mask1_r       <= {NUM_CH{1'b0}};
         mask2_r       <= {NUM_CH{1'b0}};
         ack_r         <= {NUM_CH{1'b0}};
         ptr_r         <= {CH_W{1'b0}};
         idle_r        <= {CNT_W{1'b0}};
         wr_len_r      <= 8'd0;
         wr_ovf_r      <= 1'b0;
         wr_bank_r     <= 1'b0;
         we_r          <= 1'b0;
         waddr_r       <= {(IDX_W+1){1'b0}};
         wdata_r       <= {ENTRY_W{1'b0}};
         frame_ready_r <= 1'b0;
         frame_len_r   <= 8'd0;
         frame_ovf_r   <= 1'b0;
         drop_cnt_r    <= 8'd0;
         rd_valid_r    <= 1'b0;
         rd_err_r      <= 1'b0;
      end else begin
         mask2_r    <= mask1_r;
         mask1_r    <= grant_s;
         ack_r      <= grant_s;
         we_r       <= 1'b0;
         rd_valid_r <= rd_en;
         rd_err_r   <= rd_en && rd_bad_s;
         if (gnt_any_s) begin
            ptr_r <= ptr_next_s;
         end
         if (release_s) begin
            frame_ready_r <= 1'b0;
         end
         case (state_r)
            WR_IDLE, WR_FILL: begin
               if (gnt_any_s) begin
                  state_r <= WR_FILL;
                  idle_r  <= {CNT_W{1'b0}};
                  // A full bank still acknowledges the word but drops it.
                  if (wr_len_r == 8'(DEPTH)) begin
                     wr_ovf_r <= 1'b1;
                  end else begin
                     we_r     <= 1'b1;
                     waddr_r  <= {wr_bank_r, wr_len_r[IDX_W-1:0]};
                     wdata_r  <= pack_entry(gnt_ch_s, sel_data_s, sel_ts_s);
                     wr_len_r <= wr_len_r + 8'd1;
                  end
               end else if (state_r == WR_FILL) begin
                  if (idle_r == CNT_W'(IDLE_TICKS - 1)) begin
                     state_r <= WR_CLOSE;
                  end else begin
                     idle_r <= idle_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  idle_r <= idle_r;
               end
            end
            WR_CLOSE: begin
               // A same-cycle release frees the read bank before the swap test.
               if (!frame_ready_r || release_s) begin
                  wr_bank_r     <= ~wr_bank_r;
                  frame_len_r   <= wr_len_r;
                  frame_ovf_r   <= wr_ovf_r;
                  frame_ready_r <= 1'b1;
               end else if (drop_cnt_r != 8'd255) begin
                  drop_cnt_r <= drop_cnt_r + 8'd1;
               end else begin
                  drop_cnt_r <= drop_cnt_r;
               end
               wr_len_r <= 8'd0;
               wr_ovf_r <= 1'b0;
               idle_r   <= {CNT_W{1'b0}};
               state_r  <= WR_IDLE;
            end
            default: begin
               state_r <= WR_IDLE;
            end
         endcase
      end
   end

   frame_bank_ram #(
      .AW (IDX_W + 1),
      .DW (ENTRY_W)
   ) u_ram (
      .clk   (clk_96MHz),
      .we    (we_r),
      .waddr (waddr_r),
      .wdata (wdata_r),
      .re    (rd_en),
      .raddr ({~wr_bank_r, rd_idx[IDX_W-1:0]}),
      .rdata (ram_q_s)
   );

   assign reset_bmc_decoder = ack_r;
   assign frame_ready       = frame_ready_r;
   assign frame_len         = frame_len_r;
   assign frame_ovf         = frame_ovf_r;
   assign drop_cnt          = drop_cnt_r;
   assign rd_valid          = rd_valid_r;
   assign rd_err            = rd_err_r;
   assign rd_data           = (rd_valid_r && !rd_err_r) ? ram_q_s : {ENTRY_W{1'b0}};
endmodule

// File: tb/tb_decoded_frame_buffer.sv
// Directed bench for decoded_frame_buffer: capture, arbitration, overflow,
// ping-pong drop/release and reset during fill. Short idle gap keeps runs fast.
module tb_decoded_frame_buffer;
   localparam int NCH = 4;
   localparam int DW  = 17;
   localparam int TW  = 24;
   localparam int EW  = 3 + DW + TW;
   localparam int IT  = 50;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH*DW-1:0] dd;
   logic [NCH*TW-1:0] tsd;
   logic [NCH-1:0]    avl;
   logic [NCH-1:0]    reset_bmc_decoder;
   logic              frame_ready, frame_ovf, rd_en, rd_valid, rd_err, frame_release;
   logic [7:0]        frame_len, drop_cnt, rd_idx;
   logic [EW-1:0]     rd_data;

   int checks = 0;
   int errors = 0;
   int ack_cnt [NCH];
   bit multi_ack = 1'b0;
   logic          rv, re;
   logic [EW-1:0] rdat;

   decoded_frame_buffer #(.NUM_CH(NCH), .DEPTH(196), .IDLE_TICKS(IT)) dut (
      .clk_96MHz         (clk),
      .rst_n             (rst_n),
      .decoded_data      (dd),
      .ts_decoded_data   (tsd),
      .decoded_data_avl  (avl),
      .reset_bmc_decoder (reset_bmc_decoder),
      .frame_ready       (frame_ready),
      .frame_len         (frame_len),
      .frame_ovf         (frame_ovf),
      .drop_cnt          (drop_cnt),
      .rd_en             (rd_en),
      .rd_idx            (rd_idx),
      .rd_data           (rd_data),
      .rd_valid          (rd_valid),
      .rd_err            (rd_err),
      .frame_release     (frame_release)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; the decoder model drops avl on its acknowledge pulse.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (reset_bmc_decoder[c]) ack_cnt[c]++;
      end
      if ($countones(reset_bmc_decoder) > 1) multi_ack = 1'b1;
      avl = avl & ~reset_bmc_decoder;
   endtask

   task automatic put(input int ch, input logic [DW-1:0] d, input logic [TW-1:0] t);
      dd[ch*DW +: DW] = d;
      tsd[ch*TW +: TW] = t;
      avl[ch] = 1'b1;
   endtask

   task automatic do_read(input logic [7:0] idx);
      rd_en  = 1'b1;
      rd_idx = idx;
      tick();
      rd_en  = 1'b0;
      rv     = rd_valid;
      re     = rd_err;
      rdat   = rd_data;
   endtask

   task automatic wait_ready(input string tag, input int limit);
      int n = 0;
      while (!frame_ready && n < limit) begin
         tick();
         n++;
      end
      chk(tag, 64'(frame_ready), 64'd1);
   endtask

   task automatic release_frame();
      frame_release = 1'b1;
      tick();
      frame_release = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; dd = '0; tsd = '0; avl = '0;
      rd_en = 1'b0; rd_idx = 8'd0; frame_release = 1'b0;
      for (int c = 0; c < NCH; c++) ack_cnt[c] = 0;
      tick(); tick();
      chk("rst_ready", 64'(frame_ready), 64'd0);
      chk("rst_len",   64'(frame_len),   64'd0);
      chk("rst_ovf",   64'(frame_ovf),   64'd0);
      chk("rst_drop",  64'(drop_cnt),    64'd0);
      chk("rst_ack",   64'(reset_bmc_decoder), 64'd0);
      chk("rst_rdv",   64'(rd_valid) | 64'(rd_err) | 64'(rd_data), 64'd0);
      rst_n = 1'b1;
      tick();

      // All four channels at once: order ch0..ch3, one ack each.
      for (int c = 0; c < NCH; c++) put(c, 17'h00100 + 17'(c), 24'h001000 + 24'(c));
      wait_ready("sim_ready", IT + 20);
      chk("sim_len", 64'(frame_len), 64'd4);
      chk("sim_multi_ack", 64'(multi_ack), 64'd0);
      for (int c = 0; c < NCH; c++) begin
         chk("sim_ack_cnt", 64'(ack_cnt[c]), 64'd1);
         do_read(8'(c));
         chk("sim_entry", 64'(rdat), 64'({3'(c), 17'h00100 + 17'(c), 24'h001000 + 24'(c)}));
      end
      release_frame();
      chk("sim_released", 64'(frame_ready), 64'd0);

      // Single word on ch2 with exact close timing.
      put(2, 17'h1ABCD, 24'h123456);
      tick();
      chk("one_ack", 64'(reset_bmc_decoder), 64'h4);
      tick();
      chk("one_ack_pulse", 64'(reset_bmc_decoder), 64'h0);
      repeat (IT - 1) tick();
      chk("one_close_cycle", 64'(frame_ready), 64'd0);
      tick();
      chk("one_ready", 64'(frame_ready), 64'd1);
      chk("one_len", 64'(frame_len), 64'd1);
      chk("one_ovf", 64'(frame_ovf), 64'd0);
      do_read(8'd0);
      chk("one_rd_valid", 64'(rv), 64'd1);
      chk("one_rd_err0", 64'(re), 64'd0);
      chk("one_rd_data", 64'(rdat), 64'({3'd2, 17'h1ABCD, 24'h123456}));
      do_read(8'd1);
      chk("one_rd_err1", 64'(re), 64'd1);
      chk("one_rd_zero", 64'(rdat), 64'd0);
      release_frame();

      // Overflow: 200 words on ch0 into a 196-entry bank.
      ack_cnt[0] = 0;
      for (int i = 0; i < 200; i++) begin
         put(0, 17'(i), 24'hABC000);
         repeat (3) tick();
      end
      wait_ready("ovf_ready", IT + 20);
      chk("ovf_len", 64'(frame_len), 64'd196);
      chk("ovf_flag", 64'(frame_ovf), 64'd1);
      chk("ovf_acks", 64'(ack_cnt[0]), 64'd200);
      do_read(8'd195);
      chk("ovf_last", 64'(rdat), 64'({3'd0, 17'd195, 24'hABC000}));
      do_read(8'd196);
      chk("ovf_oob_err", 64'(re), 64'd1);
      release_frame();

      // Ping-pong: frame A kept, frame B dropped.
      put(1, 17'h0AAAA, 24'h000001);
      wait_ready("pp_a_ready", IT + 20);
      put(1, 17'h0BBBB, 24'h000002);
      repeat (IT + 10) tick();
      chk("pp_drop", 64'(drop_cnt), 64'd1);
      chk("pp_len", 64'(frame_len), 64'd1);
      do_read(8'd0);
      chk("pp_a_intact", 64'(rdat), 64'({3'd1, 17'h0AAAA, 24'h000001}));
      // Frame C (2 words) closes in the same cycle as a release.
      put(3, 17'h0C001, 24'h000003);
      repeat (3) tick();
      put(3, 17'h0C002, 24'h000004);
      repeat (IT + 1) tick();
      chk("pp_pre_close_len", 64'(frame_len), 64'd1);
      release_frame();
      chk("pp_rel_ready", 64'(frame_ready), 64'd1);
      chk("pp_rel_len", 64'(frame_len), 64'd2);
      chk("pp_rel_drop", 64'(drop_cnt), 64'd1);
      do_read(8'd1);
      chk("pp_c_data", 64'(rdat), 64'({3'd3, 17'h0C002, 24'h000004}));

      // Reset in the middle of a fill.
      for (int i = 0; i < 10; i++) begin
         put(0, 17'h00200 + 17'(i), 24'h000010);
         repeat (3) tick();
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(frame_ready), 64'd0);
      chk("mid_rst_len",   64'(frame_len),   64'd0);
      chk("mid_rst_drop",  64'(drop_cnt),    64'd0);
      chk("mid_rst_ack",   64'(reset_bmc_decoder), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         put(1, 17'h00300 + 17'(i), 24'h000020);
         repeat (3) tick();
      end
      wait_ready("post_rst_ready", IT + 20);
      chk("post_rst_len", 64'(frame_len), 64'd3);
      do_read(8'd0);
      chk("post_rst_idx0", 64'(rdat), 64'({3'd1, 17'h00300, 24'h000020}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
